// File: rtl/rgb_chain_driver.sv
// rgb_chain_driver
//   Double-buffered pixel store and serial bit engine for a chain of SK6805
//   LEDs. Pixels are written into a back buffer at any time. A commit snapshots
//   the back buffer into the front buffer, and the front buffer is then shifted
//   out on LED_IO. Bits are sent G7..G0, R7..R0, B7..B0, LED 0 first. The frame
//   ends with a low latch period.
//
//   Optional feature: define RGB_BRIGHTNESS_EN to add the brightness port.
//   Each transmitted channel is then scaled to (c*brightness)>>8 at prefetch
//   time. The stored buffer contents are never modified.
//
// Ports
//   clk_100MHz  in   system clock
//   Rst         in   synchronous active-high reset
//   wr_en       in   write strobe into the back buffer
//   wr_addr     in   [5:0] LED index; indices >= NUM_LEDS are ignored
//   wr_data     in   [23:0] pixel, R[23:16] G[15:8] B[7:0]
//   commit      in   request to display the back buffer
//   brightness  in   [7:0] global scale (RGB_BRIGHTNESS_EN only)
//   busy        out  high from the first bit to the end of the latch period
//   done        out  one-cycle pulse after the latch period
//   LED_IO      out  serial data line
module rgb_chain_driver #(
  parameter int NUM_LEDS = 2,
  parameter int T0H_CYC  = 30,
  parameter int T1H_CYC  = 60,
  parameter int BIT_CYC  = 120,
  parameter int RST_CYC  = 8000
) (
  input  logic        clk_100MHz,
  input  logic        Rst,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [23:0] wr_data,
  input  logic        commit,
`ifdef RGB_BRIGHTNESS_EN
  input  logic [7:0]  brightness,
`endif
  output logic        busy,
  output logic        done,
  output logic        LED_IO
);

  localparam int CNT_MAX = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] T0_LAST  = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] T1_LAST  = CW'(T1H_CYC - 1);
  localparam logic [IW-1:0] LAST_LED = IW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, SEND_HIGH, SEND_LOW, LATCH} state_t;

  state_t         state_reg, state_next;
  logic [23:0]    back_reg  [NUM_LEDS];
  logic [23:0]    front_reg [NUM_LEDS];
  logic           pending_reg;
  logic [CW-1:0]  cyc_reg;        // position inside the bit period / latch
  logic [4:0]     bit_reg;        // bit index inside the current LED
  logic [IW-1:0]  led_idx_reg;
  logic [23:0]    shift_reg;      // current pixel in wire order, MSB out first
  logic [23:0]    prefetch_reg;   // next pixel in wire order
  logic           led_io_reg, busy_reg, done_reg;

  logic           start, bit_end, latch_end;
  logic           led_io_next, busy_next, done_next;
  logic [CW-1:0]  high_last;
  logic [IW-1:0]  next_idx;
  logic [23:0]    grb_start, grb_next, start_pix, next_pix;

  function automatic logic [23:0] wire_order(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  assign next_idx  = (led_idx_reg == LAST_LED) ? '0 : led_idx_reg + IW'(1);
  // The first pixel comes straight from the back buffer, because the front
  // buffer is only being loaded on the same edge that the frame starts.
  assign grb_start = wire_order(back_reg[0]);
  assign grb_next  = wire_order(front_reg[next_idx]);
  assign high_last = shift_reg[23] ? T1_LAST : T0_LAST;

`ifdef RGB_BRIGHTNESS_EN
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_scale
      logic [15:0] prod_start, prod_next;
      assign prod_start = 16'(grb_start[gi*8 +: 8]) * 16'(brightness);
      assign prod_next  = 16'(grb_next[gi*8 +: 8]) * 16'(brightness);
      assign start_pix[gi*8 +: 8] = prod_start[15:8];
      assign next_pix[gi*8 +: 8]  = prod_next[15:8];
    end
  endgenerate
`else
  assign start_pix = grb_start;
  assign next_pix  = grb_next;
`endif

  // Next state and output decode
  always_comb begin
    state_next  = state_reg;
    start       = 1'b0;
    bit_end     = 1'b0;
    latch_end   = 1'b0;
    case (state_reg)
      IDLE: begin
        // The cycle that carries done is the frame boundary. A queued frame
        // therefore starts from the following IDLE cycle.
        if (pending_reg && !done_reg) begin
          start      = 1'b1;
          state_next = SEND_HIGH;
        end
      end
      SEND_HIGH: begin
        if (cyc_reg == high_last) state_next = SEND_LOW;
      end
      SEND_LOW: begin
        if (cyc_reg == BIT_LAST) begin
          bit_end = 1'b1;
          if (bit_reg == 5'd23 && led_idx_reg == LAST_LED) state_next = LATCH;
          else state_next = SEND_HIGH;
        end
      end
      LATCH: begin
        if (cyc_reg == RST_LAST) begin
          latch_end  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    led_io_next = (state_next == SEND_HIGH);
    busy_next   = (state_next != IDLE);
    done_next   = latch_end;
  end

  always_ff @(posedge clk_100MHz) begin
    if (Rst) begin
      state_reg  <= IDLE;
      led_io_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      led_io_reg <= led_io_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  // Bit engine datapath
  always_ff @(posedge clk_100MHz) begin
    if (Rst) begin
      pending_reg  <= 1'b0;
      cyc_reg      <= '0;
      bit_reg      <= '0;
      led_idx_reg  <= '0;
      shift_reg    <= '0;
      prefetch_reg <= '0;
    end else begin
      pending_reg <= commit | (pending_reg & ~start);
      if (state_reg == IDLE || bit_end || latch_end) cyc_reg <= '0;
      else cyc_reg <= cyc_reg + CW'(1);

      if (start) begin
        bit_reg     <= '0;
        led_idx_reg <= '0;
        shift_reg   <= start_pix;
      end else if (bit_end) begin
        if (bit_reg == 5'd23) begin
          bit_reg     <= '0;
          led_idx_reg <= next_idx;
          shift_reg   <= prefetch_reg;
        end else begin
          bit_reg   <= bit_reg + 5'd1;
          shift_reg <= shift_reg << 1;
        end
      end

      // The front buffer is stable for the whole frame. Refreshing the prefetch
      // through every low phase therefore leaves it valid at the LED boundary.
      if (state_reg == SEND_LOW) prefetch_reg <= next_pix;
    end
  end

  // Pixel buffers
  always_ff @(posedge clk_100MHz) begin
    if (Rst) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        back_reg[i]  <= '0;
        front_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_en && wr_addr == 6'(i)) back_reg[i] <= wr_data;
        if (start) front_reg[i] <= back_reg[i];
      end
    end
  end

  assign LED_IO = led_io_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_rgb_chain_driver.sv
// tb_rgb_chain_driver
//   Directed frames with random pixel content. A line monitor decodes LED_IO
//   into pulse widths and rise times. Each frame is then compared with the bit
//   stream expected from a simple back/front buffer model.
module tb_rgb_chain_driver;

  localparam int T0 = 30;
  localparam int T1 = 60;
  localparam int BITP = 120;
  localparam int FRAME_TO_DONE = 2 * 24 * BITP + 8000;

  logic        clk = 1'b0;
  logic        rst, wr_en, commit;
  logic [5:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy, done, led_io;
`ifdef RGB_BRIGHTNESS_EN
  logic [7:0]  bright;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgb_chain_driver dut (
    .clk_100MHz (clk),
    .Rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
`ifdef RGB_BRIGHTNESS_EN
    .brightness (bright),
`endif
    .busy       (busy),
    .done       (done),
    .LED_IO     (led_io)
  );

  // Line monitor, sampled on the falling edge
  int   hi_q[$];
  int   rise_q[$];
  int   done_q[$];
  int   hi_len   = 0;
  logic led_prev = 1'b0;
  bit   in_frame = 1'b0;
  int   busy_err = 0;

  always @(negedge clk) begin
    if (rst) begin
      hi_len   = 0;
      in_frame = 1'b0;
      led_prev = 1'b0;
    end else begin
      if (led_io && !led_prev) begin
        rise_q.push_back(cyc);
        in_frame = 1'b1;
      end
      if (led_io) hi_len++;
      else if (led_prev) begin
        hi_q.push_back(hi_len);
        hi_len = 0;
      end
      if (done) begin
        done_q.push_back(cyc);
        in_frame = 1'b0;
      end
      if (in_frame && !busy) busy_err++;
      led_prev = led_io;
    end
  end

  // Reference model
  logic [23:0] mback [2];

  function automatic logic [7:0] ch_exp(input logic [7:0] c);
`ifdef RGB_BRIGHTNESS_EN
    return 8'((int'(c) * int'(bright)) / 256);
`else
    return c;
`endif
  endfunction

  // Wire order is G, R, B with the MSB first.
  function automatic logic [23:0] exp_grb(input logic [23:0] rgb);
    return {ch_exp(rgb[15:8]), ch_exp(rgb[23:16]), ch_exp(rgb[7:0])};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_px(input logic [5:0] a, input logic [23:0] d,
                          input bit with_commit, output int ccyc);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    commit  = with_commit;
    ccyc    = cyc;
    if (a < 6'd2) mback[a[0]] = d;
    $display("[%0d] write addr=%0d data=%06h commit=%0b", cyc, a, d, with_commit);
    step();
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic do_commit(output int ccyc);
    commit = 1'b1;
    ccyc   = cyc;
    $display("[%0d] commit", cyc);
    step();
    commit = 1'b0;
  endtask

  task automatic wait_rises(input string tag, input int target);
    int t = 0;
    while (rise_q.size() < target && t < 20000) begin
      step();
      t++;
    end
    chk({tag, "_rise_wait"}, longint'(rise_q.size() >= target), 1);
  endtask

  task automatic check_frame(input string tag, input int hb, input int rb, input int db,
                             input logic [23:0] p0, input logic [23:0] p1,
                             output int dcyc);
    int t = 0;
    logic [23:0] g;
    int exp_hi;
    while (done_q.size() <= db && t < 20000) begin
      step();
      t++;
    end
    chk({tag, "_done_seen"}, longint'(done_q.size() > db), 1);
    dcyc = (done_q.size() > db) ? done_q[db] : cyc;
    if (done_q.size() > db && rise_q.size() > rb)
      chk({tag, "_rise_to_done"}, done_q[db] - rise_q[rb], FRAME_TO_DONE);
    chk({tag, "_busy_low_at_done"}, busy, 0);
    chk({tag, "_pulses"}, hi_q.size() - hb, 48);
    chk({tag, "_rises"}, rise_q.size() - rb, 48);
    for (int k = 0; k < 48; k++) begin
      g = exp_grb((k < 24) ? p0 : p1);
      exp_hi = g[23 - (k % 24)] ? T1 : T0;
      if (hb + k < hi_q.size())
        chk($sformatf("%s_bit%0d_high", tag, k), hi_q[hb + k], exp_hi);
      if (k > 0 && rb + k < rise_q.size())
        chk($sformatf("%s_bit%0d_period", tag, k), rise_q[rb + k] - rise_q[rb + k - 1], BITP);
    end
    chk({tag, "_busy_err"}, busy_err, 0);
    $display("[%0d] frame %s: led0=%06h led1=%06h done at %0d", cyc, tag, p0, p1, dcyc);
  endtask

  initial begin
    int hb, rb, db, c1, c2, c3, d1, d2, dz;
    logic [23:0] f1 [2];
    logic [23:0] f2 [2];
    logic [23:0] r0, r1;

    rst = 1'b1; wr_en = 1'b0; commit = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef RGB_BRIGHTNESS_EN
    bright = 8'd255;
`endif
    mback[0] = '0; mback[1] = '0;
    repeat (3) step();
    chk("reset_led_io", led_io, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    step();

    // Frame 1. LED1 is written in the same cycle as the commit.
    hb = hi_q.size(); rb = rise_q.size(); db = done_q.size();
    write_px(6'd0, 24'hFF0000, 1'b0, c1);
    write_px(6'd1, 24'h0000FF, 1'b1, c1);
    f1 = mback;
    chk("busy_before_start", busy, 0);
    wait_rises("f1_first", rb + 1);
    if (rise_q.size() > rb) chk("commit_to_rise", rise_q[rb] - c1, 2);
    // Mid-frame write and commit, still inside LED0
    wait_rises("f1_bit10", rb + 11);
    write_px(6'd0, 24'h00FF00, 1'b1, c2);
    f2 = mback;
    check_frame("f1", hb, rb, db, f1[0], f1[1], d1);

    // Frame 2 starts automatically from the pending commit.
    hb = hi_q.size(); rb = rise_q.size(); db = done_q.size();
    step();
    chk("done_one_cycle", done, 0);
    check_frame("f2", hb, rb, db, f2[0], f2[1], d2);
    if (rise_q.size() > rb) chk("done_to_second_rise", rise_q[rb] - d1, 2);

    // Reset mid-frame, with a commit already pending
    rb = rise_q.size();
    do_commit(c3);
    wait_rises("r_bit5", rb + 6);
    do_commit(c3);
    wait_rises("r_bit10", rb + 11);
    rst = 1'b1;
    $display("[%0d] reset asserted at bit 10", cyc);
    step();
    chk("midreset_led_io", led_io, 0);
    chk("midreset_busy", busy, 0);
    rst = 1'b0;
    mback[0] = '0; mback[1] = '0;
    rb = rise_q.size();
    repeat (300) step();
    chk("reset_clears_pending", rise_q.size() - rb, 0);

    // Writes to nonexistent LEDs are ignored.
    hb = hi_q.size(); rb = rise_q.size(); db = done_q.size();
    write_px(6'd2, 24'($urandom) | 24'h010101, 1'b0, c3);
    write_px(6'($urandom_range(3, 63)), 24'hA5A5A5, 1'b0, c3);
    do_commit(c3);
    check_frame("zero", hb, rb, db, mback[0], mback[1], dz);

    // Random frame
    r0 = 24'($urandom);
    r1 = 24'($urandom);
`ifdef RGB_BRIGHTNESS_EN
    bright = 8'd128;
    r0 = 24'hFFFFFF;
`endif
    hb = hi_q.size(); rb = rise_q.size(); db = done_q.size();
    write_px(6'd0, r0, 1'b0, c3);
    write_px(6'd1, r1, 1'b0, c3);
    do_commit(c3);
    check_frame("rand", hb, rb, db, mback[0], mback[1], dz);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_chain_driver.md
RGB_CHAIN_DRIVER -- requirements
Module: rgb_chain_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 2, meaning the number of SK6805 LEDs in the chain (1..64).
REQ-002 SHALL have parameter T0H_CYC, default 30, meaning the high time of a 0-bit in clocks (300 ns).
REQ-003 SHALL have parameter T1H_CYC, default 60, meaning the high time of a 1-bit in clocks (600 ns).
REQ-004 SHALL have parameter BIT_CYC, default 120, meaning the total bit period in clocks (1.2 us).
REQ-005 SHALL have parameter RST_CYC, default 8000, meaning the latch low time in clocks (80 us).
REQ-006 SHALL have port clk_100MHz  input  1  system clock; the block uses one clock only.
REQ-007 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port wr_en  input  1  write strobe into the back pixel buffer.
REQ-009 SHALL have port wr_addr  input  6  LED index to write.
REQ-010 SHALL have port wr_data  input  24  pixel data, with R in [23:16], G in [15:8] and B in [7:0].
REQ-011 SHALL have port commit  input  1  one-cycle request to display the back buffer.
REQ-012 SHALL have port brightness  input  8  global scale factor; present only when the configuration macro is defined.
REQ-013 SHALL have port busy  output  1  high from frame start to the end of the latch period.
REQ-014 SHALL have port done  output  1  one-cycle pulse at the end of the latch period.
REQ-015 SHALL have port LED_IO  output  1  serial data line to the LED chain.

Function
REQ-016 SHALL hold two NUM_LEDS x 24 buffers: a front buffer (being transmitted) and a back buffer (being written).
REQ-017 SHALL write wr_data to back[wr_addr] on every wr_en cycle, in any state.
REQ-018 SHALL ignore writes with wr_addr >= NUM_LEDS.
REQ-019 SHALL use FSM states IDLE, SEND_HIGH, SEND_LOW and LATCH.
REQ-020 SHALL set pending on commit; a commit while pending is already set merges into it.
REQ-021 SHALL, when in IDLE with pending set, copy back to front, clear pending and enter SEND_HIGH on the next cycle.
REQ-022 SHALL include in the copy of REQ-021 any write made in the same cycle as the commit.
REQ-023 SHALL raise LED_IO on the first SEND_HIGH cycle, i.e. 2 cycles after a commit accepted in IDLE.
REQ-024 SHALL transmit LEDs in order 0 first, each as G7..G0, R7..R0, B7..B0, MSB first.
REQ-025 SHALL hold LED_IO high for T1H_CYC clocks for a 1-bit or T0H_CYC clocks for a 0-bit, then low for the remainder of BIT_CYC.
REQ-026 SHALL keep the bit period exactly BIT_CYC, with no gap between bits or between LEDs; the next pixel is prefetched during the previous bit's low phase.
REQ-027 SHALL, after the last bit's low phase, enter LATCH and hold LED_IO low for RST_CYC clocks.
REQ-028 SHALL, on LATCH completion, pulse done for 1 cycle and enter IDLE.
REQ-029 SHALL allow a commit arriving during SEND_HIGH, SEND_LOW or LATCH to set pending without disturbing the current frame; the pending frame starts from IDLE after done.
REQ-030 SHALL have a total frame time of NUM_LEDS*24*BIT_CYC + RST_CYC cycles.

Reset
REQ-031 SHALL, while Rst is high, set LED_IO=0, busy=0, done=0, pending=0, state=IDLE, and clear both buffers to 0.
REQ-032 SHALL, when Rst is asserted mid-frame, drive LED_IO low on the next clock and discard the partial frame.

Configuration
REQ-033 SHALL, with RGB_BRIGHTNESS_EN defined, scale each transmitted channel c to (c*brightness)>>8, computed at pixel prefetch and never changing the buffers; brightness=255 gives 254 for c=255.
REQ-034 SHALL, with RGB_BRIGHTNESS_EN undefined, omit the brightness port and transmit buffer values unmodified.

Verification
REQ-035 SHALL cover: write LED0=FF0000, LED1=0000FF, then commit -> bitstream G0 R1 B0 for LED0 (8x0-bit, 8x1-bit, 8x0-bit), then LED1 as 16x0-bit, 8x1-bit.
REQ-036 SHALL cover: a single commit with defaults -> done asserted exactly 5760+8000 = 13760 cycles after the first LED_IO rise; busy is high throughout.
REQ-037 SHALL cover: a write of 00FF00 plus a second commit at mid-frame -> the first frame is unchanged, and the second frame starts 2 cycles after done with the new data.
REQ-038 SHALL cover: Rst asserted at bit 10 of LED0 -> LED_IO=0 and busy=0 the next cycle, and a new commit transmits all-zero pixels.
REQ-039 SHALL cover: a write with wr_addr=2 and NUM_LEDS=2 -> no effect on either buffer.
REQ-040 SHALL cover: with RGB_BRIGHTNESS_EN defined, brightness=128 and pixel FFFFFF -> each channel transmitted as 0x7F.
